event_wake_scheduler: RTL and testbench

//  Delayed event-trigger dispatcher feeding event-driven process blocks.

---
 rtl/event_wake_scheduler_pkg.sv | 14 +
 rtl/event_wake_slot.sv | 39 +++
 rtl/event_wake_scheduler.sv | 102 ++++++++++
 tb/tb_event_wake_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/event_wake_scheduler_pkg.sv
// event_sched_pkg: shared defaults and entry types for the event wake scheduler.
package event_sched_pkg;
    localparam int NUM_EVENTS_D = 3;
    localparam int DELAY_W_D    = 4;
    localparam int DEPTH_D      = 4;
    localparam int EV_W_D       = $clog2(NUM_EVENTS_D);
    typedef logic [EV_W_D-1:0]    event_id_t;
    typedef logic [DELAY_W_D-1:0] delay_t;
    typedef struct packed {
        logic      valid;
        event_id_t ev;
        delay_t    remaining;
    } pend_entry_t;
endpackage

// File: rtl/event_wake_slot.sv
// event_wake_slot: one pending-table entry that counts its delay down and fires at zero.
module event_wake_slot #(
    parameter int EV_W    = 2,
    parameter int DELAY_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [EV_W-1:0]    i_load_ev,
    input  logic [DELAY_W-1:0] i_load_delay,
    output logic               o_valid,
    output logic               o_fire,
    output logic [EV_W-1:0]    o_ev
);
    logic               r_valid;
    logic [EV_W-1:0]    r_ev;
    logic [DELAY_W-1:0] r_rem;

    // Loads only target free entries, so load and fire never coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ev    <= '0;
            r_rem   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ev    <= i_load_ev;
            r_rem   <= i_load_delay;
        end else if (o_fire) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            r_rem   <= r_rem - 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_fire  = r_valid && (r_rem == '0);
    assign o_ev    = r_ev;
endmodule

// File: rtl/event_wake_scheduler.sv
// event_wake_scheduler: delayed event trigger dispatcher ("#D; ->E") with a small pending table.
module event_wake_scheduler
    import event_sched_pkg::*;
#(
    parameter int NUM_EVENTS = NUM_EVENTS_D,
    parameter int DELAY_W    = DELAY_W_D,
    parameter int DEPTH      = DEPTH_D
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_trig_valid,
    output logic                         o_trig_ready,
    input  logic [$clog2(NUM_EVENTS)-1:0] i_trig_event,
    input  logic [DELAY_W-1:0]           i_trig_delay,
    output logic [NUM_EVENTS-1:0]        o_wake,
    output logic                         o_merged,
    output logic [$clog2(DEPTH+1)-1:0]   o_pending_cnt,
    output logic                         o_idle,
    output logic                         o_err_bad_event
);
    localparam int EV_W  = $clog2(NUM_EVENTS);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_fire;
    logic [DEPTH-1:0]      w_free;
    logic [DEPTH-1:0]      w_load;
    logic [DEPTH-1:0]      w_next_valid;
    logic [EV_W-1:0]       w_ev [DEPTH];
    logic                  w_accept;
    logic                  w_bad;
    logic [NUM_EVENTS-1:0] w_wake;
    logic                  w_merged;
    logic [CNT_W-1:0]      w_next_cnt;

    logic [NUM_EVENTS-1:0] r_wake;
    logic                  r_merged;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_idle;
    logic                  r_err;

    assign w_free       = ~w_valid;
    assign o_trig_ready = |w_free;
    assign w_accept     = i_trig_valid && o_trig_ready;
    assign w_bad        = int'(i_trig_event) >= NUM_EVENTS;
    // Isolate the lowest set free bit; bad ids complete the handshake but are never stored.
    assign w_load       = (w_accept && !w_bad) ? (w_free & (~w_free + DEPTH'(1))) : '0;
    assign w_next_valid = (w_valid & ~w_fire) | w_load;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        event_wake_slot #(.EV_W(EV_W), .DELAY_W(DELAY_W)) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_load       (w_load[g]),
            .i_load_ev    (i_trig_event),
            .i_load_delay (i_trig_delay),
            .o_valid      (w_valid[g]),
            .o_fire       (w_fire[g]),
            .o_ev         (w_ev[g])
        );
    end

    always_comb begin
        w_wake   = '0;
        w_merged = 1'b0;
        for (int e = 0; e < NUM_EVENTS; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fire[i] && w_ev[i] == EV_W'(e)) begin
                    w_merged  = w_merged | w_wake[e];
                    w_wake[e] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next_cnt = '0;
        for (int i = 0; i < DEPTH; i++) w_next_cnt = w_next_cnt + CNT_W'(w_next_valid[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wake   <= '0;
            r_merged <= 1'b0;
            r_cnt    <= '0;
            r_idle   <= 1'b1;
            r_err    <= 1'b0;
        end else begin
            r_wake   <= w_wake;
            r_merged <= w_merged;
            r_cnt    <= w_next_cnt;
            r_idle   <= (w_next_cnt == '0);
            r_err    <= r_err | (w_accept && w_bad);
        end
    end

    assign o_wake          = r_wake;
    assign o_merged        = r_merged;
    assign o_pending_cnt   = r_cnt;
    assign o_idle          = r_idle;
    assign o_err_bad_event = r_err;
endmodule

// File: tb/tb_event_wake_scheduler.sv
// tb_event_wake_scheduler: scoreboard bench; requests are modelled as absolute fire edges.
module tb_event_wake_scheduler;
    localparam int NE    = 3;
    localparam int DP    = 4;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int acc;
        int fire;
        int ev;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig_valid = 1'b0;
    logic [1:0] trig_event = '0;
    logic [3:0] trig_delay = '0;
    logic       trig_ready;
    logic [2:0] wake;
    logic       merged;
    logic [2:0] pending_cnt;
    logic       idle;
    logic       err_bad_event;

    req_t sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   err_edge = NEVER;
    bit   started = 0;

    always #5 clk = ~clk;

    event_wake_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_trig_valid    (trig_valid),
        .o_trig_ready    (trig_ready),
        .i_trig_event    (trig_event),
        .i_trig_delay    (trig_delay),
        .o_wake          (wake),
        .o_merged        (merged),
        .o_pending_cnt   (pending_cnt),
        .o_idle          (idle),
        .o_err_bad_event (err_bad_event)
    );

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s edge=%0d got=%0d want=%0d", name, cyc, act, exp);
    endtask

    // Stored requests occupying a slot just after edge k.
    function automatic int occ(int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].acc <= k && k < sb[i].fire) n++;
        return n;
    endfunction

    always begin : mon
        int cnt_e [NE];
        int ew;
        bit em;
        @(posedge clk);
        cyc++;
        #1;
        if (started) begin
            ew = 0;
            em = 0;
            foreach (cnt_e[e]) cnt_e[e] = 0;
            foreach (sb[i]) if (sb[i].fire == cyc) cnt_e[sb[i].ev]++;
            foreach (cnt_e[e]) begin
                if (cnt_e[e] > 0) ew |= (1 << e);
                if (cnt_e[e] > 1) em = 1;
            end
            check("wake", int'(wake), ew);
            check("merged", int'(merged), int'(em));
            check("pending_cnt", int'(pending_cnt), occ(cyc));
            check("trig_ready", int'(trig_ready), int'(occ(cyc) < DP));
            check("idle", int'(idle), int'(occ(cyc) == 0));
            check("err_bad_event", int'(err_bad_event), int'(err_edge <= cyc));
            for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].fire <= cyc) sb.delete(i);
        end
    end

    // Drive one edge's inputs and predict its effect on the reference model.
    task automatic drive(bit rst, bit v, int ev, int d, output bit acc);
        int e_n;
        @(negedge clk);
        e_n = cyc + 1;
        started = 1;
        rst_n = !rst;
        trig_valid = v;
        trig_event = 2'(ev);
        trig_delay = 4'(d);
        acc = 0;
        if (rst) begin
            sb.delete();
            err_edge = NEVER;
        end else if (v && occ(e_n - 1) < DP) begin
            acc = 1;
            if (ev < NE) sb.push_back('{e_n, e_n + 1 + d, ev});
            else if (err_edge == NEVER) err_edge = e_n;
        end
    endtask

    task automatic send(int ev, int d);
        bit a = 0;
        for (int t = 0; t < 100 && !a; t++) drive(0, 1, ev, d, a);
        if (!a) begin
            n_chk++;
            $display("FAIL send_timeout edge=%0d got=not_accepted want=accepted", cyc);
        end
    endtask

    task automatic idle_n(int n);
        bit a;
        for (int t = 0; t < n; t++) drive(0, 0, 0, 0, a);
    endtask

    task automatic reset_n(int n);
        bit a;
        for (int t = 0; t < n; t++) drive(1, 0, 0, 0, a);
    endtask

    initial begin
        bit   a, hold, rst, v;
        int   ev, d;
        reset_n(2);
        send(1, 0);
        idle_n(4);
        send(0, 3);
        send(2, 1);
        idle_n(6);
        send(1, 2);
        send(1, 1);
        idle_n(5);
        for (int k = 0; k < 5; k++) send(k % NE, 15);
        idle_n(20);
        send(3, 2);
        idle_n(5);
        reset_n(1);
        for (int k = 0; k < 3; k++) send(k, 5);
        idle_n(2);
        reset_n(1);
        idle_n(10);
        hold = 0;
        ev = 0;
        d = 0;
        v = 0;
        for (int k = 0; k < 1500; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!hold) begin
                v  = ($urandom_range(0, 2) != 0);
                ev = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, NE - 1));
                d  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            end
            drive(rst, v, ev, d, a);
            hold = v && !a && !rst;
        end
        idle_n(20);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
